fetch_lsu_wb: RTL and testbench

//  Parametrised fetch + load/store writeback stage. Owns the PC, fetches instructions from port A of a

---
 rtl/fetch_lsu_wb_pkg.sv | 53 +++++
 rtl/fetch_lsu_wb_ram_be.sv | 60 ++++++
 rtl/fetch_lsu_wb.sv | 149 ++++++++++++++
 tb/tb_fetch_lsu_wb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_lsu_wb_pkg.sv
// Shared core types: fetch control, memory ops, register writeback and the load/store legality check.
package corePckg;

  localparam int cXLEN     = 32;
  localparam int cRamDepth = 1024;
  localparam int cLanes    = cXLEN / 8;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } tLsOp;

  typedef struct packed {
    logic             noOp;
    logic             newPcValid;
    logic [cXLEN-1:0] newPc;
  } tFetchCtrl;

  typedef struct packed {
    logic             read;
    logic             write;
    logic [2:0]       opType;
    logic [cXLEN-1:0] addr;
    logic [cXLEN-1:0] data;
    logic [4:0]       rdAddr;
  } tMemOp;

  typedef struct packed {
    logic             dv;
    logic [4:0]       addr;
    logic [cXLEN-1:0] data;
  } tRegOp;

  // Exactly one of read/write, a known width, and natural alignment; unsigned widths are load-only.
  function automatic logic lsLegal(input logic [2:0] opType, input logic read, input logic write,
                                   input logic [1:0] addr);
    logic ok;
    ok = read ^ write;
    case (opType)
      LS_B:    ok = ok;
      LS_H:    ok = ok & ~addr[0];
      LS_W:    ok = ok & (addr == 2'b00);
      LS_BU:   ok = ok & read;
      LS_HU:   ok = ok & read & ~addr[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fetch_lsu_wb_ram_be.sv
// True dual-port RAM, read-first, byte write enables on port B, 1 or 2 cycle read latency.
module ram_be #(
  parameter int cDepth   = 1024,
  parameter int cLatency = 1,
  parameter int cWidth   = 32
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic                      enA,
  input  logic [$clog2(cDepth)-1:0] addrA,
  output logic [cWidth-1:0]         rdDataA,
  input  logic                      enB,
  input  logic [cWidth/8-1:0]       weB,
  input  logic [$clog2(cDepth)-1:0] addrB,
  input  logic [cWidth-1:0]         wrDataB,
  output logic [cWidth-1:0]         rdDataB
);

  logic [cWidth-1:0] mem [cDepth];
  logic [cWidth-1:0] qA, qB;

  always_ff @(posedge iClk) begin
    for (int b = 0; b < cWidth / 8; b++) begin
      if (weB[b]) mem[addrB][8*b +: 8] <= wrDataB[8*b +: 8];
    end
  end

  // Non-blocking reads of mem see the pre-write contents, giving read-first collisions.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      qA <= '0;
      qB <= '0;
    end else begin
      if (enA) qA <= mem[addrA];
      if (enB) qB <= mem[addrB];
    end
  end

  generate
    if (cLatency == 2) begin : gOutReg
      logic [cWidth-1:0] q2A, q2B;
      // Port A output stage freezes with its enable so a held fetch pipe stays coherent.
      always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
          q2A <= '0;
          q2B <= '0;
        end else begin
          if (enA) q2A <= qA;
          q2B <= qB;
        end
      end
      assign rdDataA = q2A;
      assign rdDataB = q2B;
    end else begin : gNoOutReg
      assign rdDataA = qA;
      assign rdDataB = qB;
    end
  endgenerate

endmodule

// File: rtl/fetch_lsu_wb.sv
// Fetch + load/store writeback stage: PC, fetch pipe on RAM port A, byte-lane loads/stores on port B.
// Valid semantics: oInstrValid and oRegOp.dv qualify their data for exactly the cycle they are high; no backpressure.
module fetch_lsu_wb
  import corePckg::*;
#(
  parameter int               cRamDepth   = corePckg::cRamDepth,
  parameter int               cRamLatency = 1,
  parameter logic [cXLEN-1:0] cResetPc    = '0
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  tFetchCtrl        iFetchCtrl,
  input  tMemOp            iMemOp,
  output logic [cXLEN-1:0] oInstr,
  output logic [cXLEN-1:0] oCurPc,
  output logic             oInstrValid,
  output tRegOp            oRegOp,
  output logic             oFetchMisal,
  output logic             oLsErr
);

  localparam int cIdxW = $clog2(cRamDepth);
  localparam int cL    = cRamLatency;

  logic [cXLEN-1:0] pc;
  logic [cXLEN-1:0] fetchPc [cL];
  logic [cL-1:0]    fetchVld;
  logic             redirect, aligned;

  assign redirect = iFetchCtrl.newPcValid & ~iFetchCtrl.noOp;
  assign aligned  = (iFetchCtrl.newPc[1:0] == 2'b00);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      pc          <= cResetPc;
      fetchVld    <= '0;
      oFetchMisal <= 1'b0;
      for (int i = 0; i < cL; i++) fetchPc[i] <= '0;
    end else begin
      oFetchMisal <= redirect & ~aligned;
      if (!iFetchCtrl.noOp) begin
        if (redirect) begin
          fetchVld <= '0;
          if (aligned) pc <= iFetchCtrl.newPc;
        end else begin
          pc          <= pc + 32'd4;
          fetchVld[0] <= 1'b1;
          fetchPc[0]  <= pc;
          for (int i = 1; i < cL; i++) begin
            fetchVld[i] <= fetchVld[i-1];
            fetchPc[i]  <= fetchPc[i-1];
          end
        end
      end
    end
  end

  // Load/store decode
  logic             legal;
  logic [1:0]       off;
  logic [cLanes-1:0] be;
  logic [cXLEN-1:0] wrData, rdDataA, rdDataB;
  logic             unusedAddrBits;

  assign off            = iMemOp.addr[1:0];
  assign legal          = lsLegal(iMemOp.opType, iMemOp.read, iMemOp.write, off);
  assign unusedAddrBits = ^iMemOp.addr[cXLEN-1:cIdxW+2];

  always_comb begin
    be     = '0;
    wrData = iMemOp.data;
    case (iMemOp.opType)
      LS_B: begin
        be     = 4'b0001 << off;
        wrData = {4{iMemOp.data[7:0]}};
      end
      LS_H: begin
        be     = 4'b0011 << off;
        wrData = {2{iMemOp.data[15:0]}};
      end
      LS_W:    be = 4'b1111;
      default: be = '0;
    endcase
    if (!(legal && iMemOp.write)) be = '0;
  end

  ram_be #(.cDepth(cRamDepth), .cLatency(cL), .cWidth(cXLEN)) uRam (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .enA     (~iFetchCtrl.noOp),
    .addrA   (pc[cIdxW+1:2]),
    .rdDataA (rdDataA),
    .enB     (legal & iMemOp.read),
    .weB     (be),
    .addrB   (iMemOp.addr[cIdxW+1:2]),
    .wrDataB (wrData),
    .rdDataB (rdDataB)
  );

  logic [cL-1:0] ldVld;
  logic [2:0]    ldType [cL];
  logic [1:0]    ldOff  [cL];
  logic [4:0]    ldRd   [cL];

  // Load attributes ride alongside the RAM read; writes to x0 never raise dv.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      ldVld  <= '0;
      oLsErr <= 1'b0;
      for (int i = 0; i < cL; i++) begin
        ldType[i] <= '0;
        ldOff[i]  <= '0;
        ldRd[i]   <= '0;
      end
    end else begin
      oLsErr    <= (iMemOp.read | iMemOp.write) & ~legal;
      ldVld[0]  <= legal & iMemOp.read & (iMemOp.rdAddr != 5'd0);
      ldType[0] <= iMemOp.opType;
      ldOff[0]  <= off;
      ldRd[0]   <= iMemOp.rdAddr;
      for (int i = 1; i < cL; i++) begin
        ldVld[i]  <= ldVld[i-1];
        ldType[i] <= ldType[i-1];
        ldOff[i]  <= ldOff[i-1];
        ldRd[i]   <= ldRd[i-1];
      end
    end
  end

  logic [cXLEN-1:0] lane;

  always_comb begin
    lane        = rdDataB >> {ldOff[cL-1], 3'b000};
    oRegOp.dv   = ldVld[cL-1];
    oRegOp.addr = ldRd[cL-1];
    case (ldType[cL-1])
      LS_B:    oRegOp.data = {{24{lane[7]}}, lane[7:0]};
      LS_BU:   oRegOp.data = {24'h0, lane[7:0]};
      LS_H:    oRegOp.data = {{16{lane[15]}}, lane[15:0]};
      LS_HU:   oRegOp.data = {16'h0, lane[15:0]};
      default: oRegOp.data = rdDataB;
    endcase
  end

  assign oInstr      = rdDataA;
  assign oCurPc      = fetchPc[cL-1];
  assign oInstrValid = fetchVld[cL-1];

endmodule

// File: tb/tb_fetch_lsu_wb.sv
// Directed bench for fetch_lsu_wb: latency 1 and latency 2 instances driven in lockstep.
module tb_fetch_lsu_wb;
  import corePckg::*;

  logic      iClk = 1'b0;
  logic      iRstN = 1'b1;
  tFetchCtrl fetchCtrl;
  tMemOp     memOp;

  logic [31:0] instr1, pc1, instr2, pc2;
  logic        vld1, vld2, misal1, misal2, err1, err2;
  tRegOp       regOp1, regOp2;

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  fetch_lsu_wb #(.cRamLatency(1)) dut1 (
    .iClk(iClk), .iRstN(iRstN), .iFetchCtrl(fetchCtrl), .iMemOp(memOp),
    .oInstr(instr1), .oCurPc(pc1), .oInstrValid(vld1), .oRegOp(regOp1),
    .oFetchMisal(misal1), .oLsErr(err1)
  );

  fetch_lsu_wb #(.cRamLatency(2)) dut2 (
    .iClk(iClk), .iRstN(iRstN), .iFetchCtrl(fetchCtrl), .iMemOp(memOp),
    .oInstr(instr2), .oCurPc(pc2), .oInstrValid(vld2), .oRegOp(regOp2),
    .oFetchMisal(misal2), .oLsErr(err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkFetch(input string tag, input logic vObs, input logic [31:0] pcObs,
                            input logic [31:0] instrObs, input logic vExp,
                            input logic [31:0] pcExp, input logic [31:0] instrExp);
    check({tag, "_vld"}, 32'(vObs), 32'(vExp));
    if (vExp) begin
      check({tag, "_pc"}, pcObs, pcExp);
      check({tag, "_instr"}, instrObs, instrExp);
    end
  endtask

  task automatic checkReg(input string tag, input tRegOp obs, input logic dvExp,
                          input logic [4:0] rdExp, input logic [31:0] dataExp);
    check({tag, "_dv"}, 32'(obs.dv), 32'(dvExp));
    if (dvExp) begin
      check({tag, "_rd"}, 32'(obs.addr), 32'(rdExp));
      check({tag, "_data"}, obs.data, dataExp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic setOp(input logic rd, input logic wr, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    memOp.read   = rd;
    memOp.write  = wr;
    memOp.opType = t;
    memOp.addr   = a;
    memOp.data   = d;
    memOp.rdAddr = r;
  endtask

  initial begin
    fetchCtrl = '0;
    memOp     = '0;
    #1 iRstN = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      dut1.uRam.mem[k] = 32'h1000 + 32'(k);
      dut2.uRam.mem[k] = 32'h1000 + 32'(k);
    end
    #2;
    check("rst_vld1", 32'(vld1), 32'd0);
    check("rst_instr1", instr1, 32'h0);
    check("rst_pc1", pc1, 32'h0);
    check("rst_dv1", 32'(regOp1.dv), 32'd0);
    check("rst_misal1", 32'(misal1), 32'd0);
    check("rst_err1", 32'(err1), 32'd0);
    check("rst_vld2", 32'(vld2), 32'd0);

    // Release between edges; the first edge afterwards issues the first fetch
    @(posedge iClk);
    #3 iRstN = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      checkFetch("t1_l1", vld1, pc1, instr1, 1'b1, 32'(4 * (n - 1)), 32'h1000 + 32'(n - 1));
      checkFetch("t1_l2", vld2, pc2, instr2, n >= 2, 32'(4 * (n - 2)), 32'h1000 + 32'(n - 2));
    end

    // Redirect with fetches in flight
    fetchCtrl.newPcValid = 1'b1;
    fetchCtrl.newPc      = 32'h40;
    tick();
    fetchCtrl = '0;
    check("t2_squash_l1", 32'(vld1), 32'd0);
    check("t2_squash_l2", 32'(vld2), 32'd0);
    tick();
    checkFetch("t2_tgt_l1", vld1, pc1, instr1, 1'b1, 32'h40, 32'h1010);
    check("t2_wait_l2", 32'(vld2), 32'd0);
    tick();
    checkFetch("t2_next_l1", vld1, pc1, instr1, 1'b1, 32'h44, 32'h1011);
    checkFetch("t2_tgt_l2", vld2, pc2, instr2, 1'b1, 32'h40, 32'h1010);

    // Misaligned redirect: pulse, squash, PC held at 0x48
    fetchCtrl.newPcValid = 1'b1;
    fetchCtrl.newPc      = 32'h42;
    tick();
    fetchCtrl = '0;
    check("t2_misal1", 32'(misal1), 32'd1);
    check("t2_misal2", 32'(misal2), 32'd1);
    check("t2_misal_vld1", 32'(vld1), 32'd0);
    tick();
    check("t2_misal_end", 32'(misal1), 32'd0);
    checkFetch("t2_held_l1", vld1, pc1, instr1, 1'b1, 32'h48, 32'h1012);
    tick();
    checkFetch("t2_held_l2", vld2, pc2, instr2, 1'b1, 32'h48, 32'h1012);

    // Stores then loads of the merged word
    setOp(1'b0, 1'b1, LS_W, 32'h10, 32'hAABBCCDD, 5'd0);
    tick();
    check("t3_sw_err", 32'(err1), 32'd0);
    setOp(1'b0, 1'b1, LS_B, 32'h12, 32'h11, 5'd0);
    tick();
    checkReg("t3_sb_l1", regOp1, 1'b0, 5'd0, 32'h0);
    setOp(1'b1, 1'b0, LS_W, 32'h10, 32'h0, 5'd5);
    tick();
    checkReg("t3_lw_l1", regOp1, 1'b1, 5'd5, 32'hAA11CCDD);
    checkReg("t3_lw_l2_early", regOp2, 1'b0, 5'd0, 32'h0);
    setOp(1'b1, 1'b0, LS_B, 32'h13, 32'h0, 5'd6);
    tick();
    checkReg("t3_lb_l1", regOp1, 1'b1, 5'd6, 32'hFFFFFFAA);
    checkReg("t3_lw_l2", regOp2, 1'b1, 5'd5, 32'hAA11CCDD);
    setOp(1'b1, 1'b0, LS_BU, 32'h13, 32'h0, 5'd7);
    tick();
    checkReg("t3_lbu_l1", regOp1, 1'b1, 5'd7, 32'h000000AA);
    checkReg("t3_lb_l2", regOp2, 1'b1, 5'd6, 32'hFFFFFFAA);
    setOp(1'b1, 1'b0, LS_H, 32'h12, 32'h0, 5'd8);
    tick();
    checkReg("t3_lh_l1", regOp1, 1'b1, 5'd8, 32'hFFFFAA11);
    checkReg("t3_lbu_l2", regOp2, 1'b1, 5'd7, 32'h000000AA);
    memOp = '0;
    tick();
    checkReg("t3_idle_l1", regOp1, 1'b0, 5'd0, 32'h0);
    checkReg("t3_lh_l2", regOp2, 1'b1, 5'd8, 32'hFFFFAA11);
    tick();
    checkReg("t3_idle_l2", regOp2, 1'b0, 5'd0, 32'h0);

    // Illegal accesses are dropped with an error pulse
    setOp(1'b1, 1'b0, LS_H, 32'h11, 32'h0, 5'd9);
    tick();
    check("t4_lh_misal_err", 32'(err1), 32'd1);
    checkReg("t4_lh_misal", regOp1, 1'b0, 5'd0, 32'h0);
    setOp(1'b0, 1'b1, LS_W, 32'h12, 32'h12345678, 5'd0);
    tick();
    check("t4_sw_misal_err", 32'(err1), 32'd1);
    check("t4_sw_misal_err2", 32'(err2), 32'd1);
    setOp(1'b1, 1'b1, LS_W, 32'h10, 32'h0, 5'd10);
    tick();
    check("t4_rw_err", 32'(err1), 32'd1);
    checkReg("t4_rw", regOp1, 1'b0, 5'd0, 32'h0);
    setOp(1'b1, 1'b0, LS_W, 32'h10, 32'h0, 5'd0);
    tick();
    check("t4_x0_err", 32'(err1), 32'd0);
    checkReg("t4_x0", regOp1, 1'b0, 5'd0, 32'h0);
    checkReg("t4_rw_l2", regOp2, 1'b0, 5'd0, 32'h0);
    setOp(1'b1, 1'b0, LS_W, 32'h10, 32'h0, 5'd11);
    tick();
    checkReg("t4_unchanged_l1", regOp1, 1'b1, 5'd11, 32'hAA11CCDD);
    checkReg("t4_x0_l2", regOp2, 1'b0, 5'd0, 32'h0);
    memOp = '0;
    tick();
    checkReg("t4_unchanged_l2", regOp2, 1'b1, 5'd11, 32'hAA11CCDD);

    // noOp freezes fetch while a load still writes back
    fetchCtrl.newPcValid = 1'b1;
    fetchCtrl.newPc      = 32'h100;
    tick();
    fetchCtrl = '0;
    tick();
    checkFetch("t5_pre_l1", vld1, pc1, instr1, 1'b1, 32'h100, 32'h1040);
    tick();
    checkFetch("t5_pre2_l1", vld1, pc1, instr1, 1'b1, 32'h104, 32'h1041);
    checkFetch("t5_pre2_l2", vld2, pc2, instr2, 1'b1, 32'h100, 32'h1040);
    fetchCtrl.noOp = 1'b1;
    setOp(1'b1, 1'b0, LS_W, 32'h10, 32'h0, 5'd12);
    tick();
    memOp = '0;
    checkFetch("t5_hold1_l1", vld1, pc1, instr1, 1'b1, 32'h104, 32'h1041);
    checkFetch("t5_hold1_l2", vld2, pc2, instr2, 1'b1, 32'h100, 32'h1040);
    checkReg("t5_load_l1", regOp1, 1'b1, 5'd12, 32'hAA11CCDD);
    tick();
    checkFetch("t5_hold2_l1", vld1, pc1, instr1, 1'b1, 32'h104, 32'h1041);
    checkFetch("t5_hold2_l2", vld2, pc2, instr2, 1'b1, 32'h100, 32'h1040);
    checkReg("t5_load_l2", regOp2, 1'b1, 5'd12, 32'hAA11CCDD);
    tick();
    checkFetch("t5_hold3_l1", vld1, pc1, instr1, 1'b1, 32'h104, 32'h1041);
    fetchCtrl.noOp = 1'b0;
    tick();
    checkFetch("t5_resume_l1", vld1, pc1, instr1, 1'b1, 32'h108, 32'h1042);
    checkFetch("t5_resume_l2", vld2, pc2, instr2, 1'b1, 32'h104, 32'h1041);

    // Asynchronous reset mid-load and mid-fetch
    setOp(1'b1, 1'b0, LS_W, 32'h10, 32'h0, 5'd13);
    tick();
    memOp = '0;
    checkReg("t6_pre_l1", regOp1, 1'b1, 5'd13, 32'hAA11CCDD);
    #3 iRstN = 1'b0;
    #1;
    check("t6_async_vld1", 32'(vld1), 32'd0);
    check("t6_async_instr1", instr1, 32'h0);
    check("t6_async_pc1", pc1, 32'h0);
    check("t6_async_dv1", 32'(regOp1.dv), 32'd0);
    check("t6_async_data1", regOp1.data, 32'h0);
    check("t6_async_vld2", 32'(vld2), 32'd0);
    check("t6_async_instr2", instr2, 32'h0);
    check("t6_async_dv2", 32'(regOp2.dv), 32'd0);
    @(posedge iClk);
    #3 iRstN = 1'b1;
    tick();
    checkFetch("t6_restart_l1", vld1, pc1, instr1, 1'b1, 32'h0, 32'h1000);
    checkReg("t6_nostale_l1", regOp1, 1'b0, 5'd0, 32'h0);
    check("t6_restart_vld2", 32'(vld2), 32'd0);
    checkReg("t6_nostale_l2", regOp2, 1'b0, 5'd0, 32'h0);
    tick();
    checkFetch("t6_restart_l2", vld2, pc2, instr2, 1'b1, 32'h0, 32'h1000);
    checkReg("t6_nostale2_l2", regOp2, 1'b0, 5'd0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
